tpu_host_seq: RTL

//  Host-side initiator for the tt_um_tpu pin protocol. On start, it streams a 2x2 A and a 2x2 B

---
 rtl/tpu_host_seq_pkg.sv | 36 +++
 rtl/tpu_wait_timer.sv | 27 ++
 rtl/tpu_host_seq.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/tpu_host_seq_pkg.sv
// Shared definitions for the TPU host sequencer: FSM states and uio_in control bit layout.
package tpu_host_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_READ      = 3'd3,
        ST_RESULT    = 3'd4
    } state_t;

    // uio_in bit positions, identical to the TPU top's decode
    localparam int LOAD_EN_BIT = 0;
    localparam int SEL_AB_BIT  = 1;
    localparam int IDX_LSB     = 2;
    localparam int OUT_EN_BIT  = 4;
    localparam int OUT_SEL_LSB = 5;

    function automatic logic [7:0] load_ctrl(input logic sel_ab, input logic [1:0] idx);
        logic [7:0] c;
        c                 = '0;
        c[LOAD_EN_BIT]    = 1'b1;
        c[SEL_AB_BIT]     = sel_ab;
        c[IDX_LSB +: 2]   = idx;
        return c;
    endfunction

    function automatic logic [7:0] read_ctrl(input logic [1:0] sel);
        logic [7:0] c;
        c                   = '0;
        c[OUT_EN_BIT]       = 1'b1;
        c[OUT_SEL_LSB +: 2] = sel;
        return c;
    endfunction

endpackage

// File: rtl/tpu_wait_timer.sv
// Loadable down-counter; o_expired is high while the count sits at zero.
// Loading N-1 therefore yields an N-cycle wait ending on the expired cycle.
module tpu_wait_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_expired
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/tpu_host_seq.sv
// Host-side initiator for the tt_um_tpu pin protocol: loads 2x2 A and B,
// waits for a fresh done, then reads back the four C elements.
module tpu_host_seq
    import tpu_host_seq_pkg::*;
#(
    parameter int LOAD_GAP = 1,
    parameter int READ_LAT = 2,
    parameter int TIMEOUT  = 255,
    parameter int TO_W     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a_mat,
    input  logic [31:0] b_mat,
    input  logic [7:0]  tpu_out,
    input  logic        tpu_done,
    output logic [7:0]  tpu_in,
    output logic [7:0]  tpu_ctrl,
    output logic        busy,
    output logic        result_valid,
    output logic [31:0] c_mat,
    output logic        err
);

    // Timer reload values are wait length minus one (see tpu_wait_timer)
    localparam logic [TO_W-1:0] GAP_LD = (LOAD_GAP > 0) ? TO_W'(LOAD_GAP - 1) : '0;
    localparam logic [TO_W-1:0] RL_LD  = TO_W'(READ_LAT - 1);
    localparam logic [TO_W-1:0] TO_LD  = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

    state_t      r_state;
    logic [63:0] r_snap;
    logic [2:0]  r_beat;
    logic        r_in_gap;
    logic [1:0]  r_elem;
    logic [23:0] r_shadow;
    logic        r_done_q;
    logic        r_done_low_seen;
    logic [7:0]  r_tpu_in;
    logic [7:0]  r_tpu_ctrl;
    logic        r_busy;
    logic        r_result_valid;
    logic [31:0] r_c_mat;
    logic        r_err;

    logic            w_tmr_load;
    logic [TO_W-1:0] w_tmr_val;
    logic            w_tmr_exp;
    logic            w_beat_end;
    logic            w_done_ok;
    logic            w_timeout;
    logic [2:0]      w_next_beat;
    logic [1:0]      w_next_elem;

    assign w_beat_end  = r_in_gap ? w_tmr_exp : (LOAD_GAP == 0);
    assign w_done_ok   = r_done_q && r_done_low_seen;
    assign w_timeout   = (TIMEOUT != 0) && w_tmr_exp;
    assign w_next_beat = r_beat + 3'd1;
    assign w_next_elem = r_elem + 2'd1;

    tpu_wait_timer #(.W(TO_W)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_tmr_load),
        .i_val     (w_tmr_val),
        .o_expired (w_tmr_exp)
    );

    // One timer serves all three waits since they never overlap
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        case (r_state)
            ST_LOAD: begin
                if (!r_in_gap && LOAD_GAP != 0) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = GAP_LD;
                end else if (w_beat_end && r_beat == 3'd7) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = TO_LD;
                end
            end
            ST_WAIT_DONE: begin
                if (w_done_ok) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = RL_LD;
                end
            end
            ST_READ: begin
                if (w_tmr_exp && r_elem != 2'd3) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = RL_LD;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_snap          <= '0;
            r_beat          <= '0;
            r_in_gap        <= 1'b0;
            r_elem          <= '0;
            r_shadow        <= '0;
            r_done_q        <= 1'b0;
            r_done_low_seen <= 1'b0;
            r_tpu_in        <= '0;
            r_tpu_ctrl      <= '0;
            r_busy          <= 1'b0;
            r_result_valid  <= 1'b0;
            r_c_mat         <= '0;
            r_err           <= 1'b0;
        end else begin
            r_done_q       <= tpu_done;
            r_result_valid <= 1'b0;
            r_err          <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_snap          <= {b_mat, a_mat};
                        r_beat          <= '0;
                        r_in_gap        <= 1'b0;
                        r_done_low_seen <= 1'b0;
                        r_tpu_in        <= a_mat[7:0];
                        r_tpu_ctrl      <= load_ctrl(1'b0, 2'd0);
                        r_busy          <= 1'b1;
                        r_state         <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!r_done_q) r_done_low_seen <= 1'b1;
                    if (!r_in_gap && LOAD_GAP != 0) begin
                        r_in_gap                <= 1'b1;
                        r_tpu_ctrl[LOAD_EN_BIT] <= 1'b0;
                    end else if (w_beat_end) begin
                        r_in_gap <= 1'b0;
                        if (r_beat == 3'd7) begin
                            r_tpu_in   <= '0;
                            r_tpu_ctrl <= '0;
                            r_state    <= ST_WAIT_DONE;
                        end else begin
                            // Beats 0..3 come from A, 4..7 from B: bit 2 is sel_ab
                            r_beat     <= w_next_beat;
                            r_tpu_in   <= r_snap[{w_next_beat, 3'b000} +: 8];
                            r_tpu_ctrl <= load_ctrl(w_next_beat[2], w_next_beat[1:0]);
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    if (!r_done_q) r_done_low_seen <= 1'b1;
                    if (w_done_ok) begin
                        r_elem     <= '0;
                        r_tpu_ctrl <= read_ctrl(2'd0);
                        r_state    <= ST_READ;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (w_tmr_exp) begin
                        if (r_elem == 2'd3) begin
                            r_c_mat        <= {tpu_out, r_shadow};
                            r_result_valid <= 1'b1;
                            r_tpu_ctrl     <= '0;
                            r_state        <= ST_RESULT;
                        end else begin
                            r_shadow[{r_elem, 3'b000} +: 8] <= tpu_out;
                            r_elem     <= w_next_elem;
                            r_tpu_ctrl <= read_ctrl(w_next_elem);
                        end
                    end
                end
                ST_RESULT: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tpu_in       = r_tpu_in;
    assign tpu_ctrl     = r_tpu_ctrl;
    assign busy         = r_busy;
    assign result_valid = r_result_valid;
    assign c_mat        = r_c_mat;
    assign err          = r_err;

endmodule
